// File: rtl/reg_pipe_hs.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble collapsing and flush.
// Define REG_PIPE_OCC_EN to add the registered occupancy counter output occ.
module reg_pipe_hs #(
    parameter int DATA_W     = 20,
    parameter int DEPTH      = 2,
    parameter     PRESET_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    localparam logic [DATA_W-1:0] PRESET_D = DATA_W'(PRESET_VAL);

    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];
    logic [DEPTH-1:0]  adv;
    logic              clear;
    logic              in_xfer;
    logic              out_xfer;

    assign clear     = rst || flush;
    assign in_ready  = adv[0] && !clear;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_xfer  = out_valid && out_ready;

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        adv = '0;
        adv[DEPTH-1] = !v[DEPTH-1] || out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = !v[i] || adv[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: sequential state uses non-blocking assignments so all stages shift off the same old values.
            v <= '0;
            // NOTE: the data registers are deliberately reset, because the preset value is visible on out_data.
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= PRESET_D;
            end
        end else begin
            if (adv[0]) begin
                v[0] <= in_xfer;
                if (in_xfer) begin
                    d[0] <= in_data;
                end
            end
            // Bubbles advance the valid bit only; data holds to avoid needless toggling.
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                    end
                end
            end
        end
    end

`ifdef REG_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    always_ff @(posedge clk) begin
        if (clear) begin
            occ <= '0;
        end else begin
            case ({in_xfer, out_xfer})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Scoreboard bench for reg_pipe_hs: directed reset/stream/stall/flush cases plus a random run.
// Exercises occ only when REG_PIPE_OCC_EN is defined.
module tb_reg_pipe_hs;

    localparam int              DATA_W = 20;
    localparam int              DEPTH  = 3;
    localparam logic [DATA_W-1:0] PRESET = 20'h5A5A5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
`ifdef REG_PIPE_OCC_EN
    logic [$clog2(DEPTH+1)-1:0] occ;
`endif

    reg_pipe_hs #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .PRESET_VAL (PRESET)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef REG_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] sb [$];
    logic              last_in_xfer  = 1'b0;
    logic              last_out_xfer = 1'b0;
    logic              stall_prev    = 1'b0;
    logic [DATA_W-1:0] prev_data     = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, compare outputs, update the scoreboard.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
        logic [DATA_W-1:0] exp;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
`ifdef REG_PIPE_OCC_EN
        check("occ", 32'(occ), 32'(sb.size()));
        check("occ_max", 32'(occ <= DEPTH), 32'd1);
`endif
        check("in_ready", 32'(in_ready), 32'(!fl && ((sb.size() < DEPTH) || ordy)));
        if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && sb.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
        end
        last_out_xfer = out_valid && ordy && !fl;
        last_in_xfer  = iv && in_ready;
        if (last_out_xfer && sb.size() > 0) begin
            exp = sb.pop_front();
            check("out_data", 32'(out_data), 32'(exp));
        end
        if (last_in_xfer) sb.push_back(id);
        if (fl) sb.delete();
        stall_prev = out_valid && !ordy && !fl;
        prev_data  = out_data;
    endtask

    initial begin
        int first_in, first_out, last_out, n_out, budget;
        logic [DATA_W-1:0] vals [4];

        // Reset held for two edges.
        @(negedge clk); #1;
        check("rst_ready0", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'(PRESET));
        @(negedge clk); #1;
        check("rst_ready1", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_data", 32'(out_data), 32'(PRESET));
`ifdef REG_PIPE_OCC_EN
        check("post_rst_occ", 32'(occ), 32'd0);
`endif

        // Back-to-back streaming with no back-pressure.
        first_in = -1; first_out = -1; last_out = -1; n_out = 0;
        for (int c = 0; c < 14; c++) begin
            cycle(c < 8, DATA_W'(c + 1), 1'b1, 1'b0);
            if (c < 8) check("stream_accept", 32'(last_in_xfer), 32'd1);
            if (last_in_xfer && first_in < 0) first_in = c;
            if (last_out_xfer) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                n_out++;
            end
        end
        check("stream_latency", 32'(first_out - first_in), 32'(DEPTH));
        check("stream_count", 32'(n_out), 32'd8);
        check("stream_no_gap", 32'(last_out - first_out), 32'd7);

        // Fill under stall: only DEPTH items fit.
        vals = '{20'h10, 20'h20, 20'h30, 20'h40};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, vals[k], 1'b0, 1'b0);
            check("fill_accept", 32'(last_in_xfer), 32'(k < DEPTH));
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, vals[3], 1'b0, 1'b0);
            check("full_valid", 32'(out_valid), 32'd1);
            check("full_head", 32'(out_data), 32'h10);
        end

        // Full pass-through: one in and one out on the same edge.
        cycle(1'b1, vals[3], 1'b1, 1'b0);
        check("pass_in", 32'(last_in_xfer), 32'd1);
        check("pass_out", 32'(last_out_xfer), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            check("drain_no_gap", 32'(last_out_xfer), 32'd1);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);

        // Flush with two items inside and a new offer in the flush cycle.
        cycle(1'b1, 20'hA1, 1'b0, 1'b0);
        cycle(1'b1, 20'hA2, 1'b0, 1'b0);
        cycle(1'b1, 20'h77, 1'b0, 1'b1);
        check("flush_drop", 32'(last_in_xfer), 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_data", 32'(out_data), 32'(PRESET));
        for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Random handshakes against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            cycle($urandom_range(0, 3) != 0, DATA_W'($urandom), $urandom_range(0, 2) != 0, 1'b0);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 50) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            budget++;
        end
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
